escalonador_vozes: RTL and testbench
====================================

# escalonador_vozes

Polyphonic voice scheduler for the wavetable `instrumento` voices. It accepts note-on requests carrying a pitch divisor and allocates each to a free voice. Per voice it generates the `prox` step strobe at the requested rate and the `ativo` gate, and sequences note release so that each voice stops on a sample-cycle boundary. It sits between the note/key front end and an array of `NUM_VOZES` `instrumento` instances, bit *v* of `prox`/`ativo` driving instance *v*.

## Interface
- `NUM_VOZES`, default 4: number of voices; must be a power of 2, ≥ 2.
- `LARGURA_DIV`, default 16: width of the pitch divisor.
- `SAMPLE_SIZE`, default 8: steps per wavetable cycle; must be a power of 2 and match `instrumento`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `nota_valida` in 1: note-on request valid.
- `nota_div` in `LARGURA_DIV`: clocks per wavetable step.
- `nota_pronta` out 1: ready; a request is accepted on a cycle with `nota_valida && nota_pronta`.
- `nota_aceita` out 1: registered; one-cycle pulse the cycle after acceptance.
- `nota_voz` out log2(`NUM_VOZES`): registered; voice assigned to the last accepted note, held until the next acceptance.
- `solta_valida` in 1: note-off request, always accepted.
- `solta_voz` in log2(`NUM_VOZES`): voice to release.
- `prox` out `NUM_VOZES`: registered one-cycle step strobes.
- `ativo` out `NUM_VOZES`: registered voice gates.
- `ocupado` out `NUM_VOZES`: voice not LIVRE.

## Operation
- **Per-voice state machine:** LIVRE, INICIO, TOCANDO, LIBERANDO.
  - Each voice holds a divider counter (`LARGURA_DIV`) and a phase `fase` (log2 `SAMPLE_SIZE`).
- **Effective divisor:** Nd = max(`nota_div`, 2).
- **Allocation on acceptance:** the target is the lowest-index LIVRE voice.
  - The target voice goes to INICIO.
  - Nd is latched, `fase` is cleared, the counter is loaded with Nd−1, and `nota_voz` is set to the target.
- **INICIO (exactly 1 cycle):** `prox`=1, `ativo`=0.
  - This resets the `instrumento` index to sample[0].
  - Next state is TOCANDO.
- **TOCANDO:** `ativo`=1.
  - The counter decrements each cycle.
  - At counter 0: `prox`=1, the counter reloads to Nd−1, and `fase` increments mod `SAMPLE_SIZE`.
- **Note-off in TOCANDO:** moves the voice to LIBERANDO, or straight to LIVRE if `fase`==0.
- **Note-off in INICIO:** moves the voice to LIVRE.
- **Note-off in LIVRE or LIBERANDO:** ignored.
- **LIBERANDO:** same stepping as TOCANDO, `ativo`=1.
  - On the strobe that wraps `fase` to 0, the next state is LIVRE.
  - That strobe is emitted with `ativo`=1, so the instance lands on sample[0].
- **LIVRE:** `ativo`=0, `prox`=0; the counter is frozen.
- **Same-cycle note-on and note-off for one voice:** the note-on wins and the note-off is dropped.
- **Note-on and note-off for different voices in one cycle:** both are applied.
- **Allocation priority:** note-off is evaluated before allocation. A voice released straight to LIVRE in the current cycle is not allocatable until the next cycle.
- **Reset:** all voices LIVRE; `prox`, `ativo`, `nota_aceita`, `nota_voz`, counters, `fase` and the steal pointer all 0. Reset mid-note silences all voices immediately.

## Timing
- Acceptance happens at edge t.
- At t+1: `nota_aceita`=1, `nota_voz` is valid, and the voice is in INICIO with its reset strobe.
- First gated strobe comes Nd cycles after the INICIO strobe. Subsequent strobes are every Nd cycles.
- `nota_pronta` is combinational from current voice state (OR of LIVRE flags).
- Back-to-back acceptances are allowed every cycle.
- Release latency: from note-off to LIVRE is at most `SAMPLE_SIZE`·Nd cycles.

## Configuration
- **`VOICE_STEAL_EN` defined:**
  - `nota_pronta` is tied to 1.
  - If no voice is LIVRE, the target is the lowest-index LIBERANDO voice.
  - Otherwise the target is the voice at a round-robin steal pointer, which then increments mod `NUM_VOZES`.
  - A stolen voice re-enters INICIO, identically to a fresh allocation.
- **Undefined:**
  - `nota_pronta` = any voice LIVRE.
  - No stealing logic or pointer exists.
  - With all voices busy, a request waits.

## Test plan
- **Reset:** assert `rst_n`=0 mid-note → all outputs 0 immediately; `ocupado`=0 after release.
- **Single note:** `nota_div`=5 → INICIO strobe with `ativo`=0, then `prox` pulses every 5 cycles with `ativo`=1.
  - `nota_voz`=0, and the `instrumento` output follows 127, 219, 255, …
- **Release:** note-off after 3 steps → 5 more strobes, then `ativo`=0 and `ocupado[0]`=0, with `saida`=127.
  - Note-off at `fase`=0 → LIVRE the next cycle.
- **Minimum divisor:** `nota_div`=0 and 1 → strobes every 2 cycles.
- **Fill:** four notes on consecutive cycles → `nota_voz` = 0, 1, 2, 3, then `nota_pronta`=0 (no macro).
  - A fifth request waits until the first release completes and then takes that voice.
- **Stealing (macro defined):** all TOCANDO plus two requests → voices 0 then 1 are stolen and each re-enters INICIO.
  - With voice 2 in LIBERANDO, voice 2 is taken first.

Source files
------------

// File: rtl/escalonador_vozes.sv
// escalonador_vozes: polyphonic voice scheduler for wavetable instrumento voices.
// Allocates note-on requests to free voices and generates, per voice, the prox
// step strobe and the ativo gate. Releases always finish on a sample-cycle boundary.
// Optional feature: define VOICE_STEAL_EN to steal a busy voice when none is free.
module escalonador_vozes #(
  parameter int NUM_VOZES   = 4,
  parameter int LARGURA_DIV = 16,
  parameter int SAMPLE_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         nota_valida,
  input  logic [LARGURA_DIV-1:0]       nota_div,
  output logic                         nota_pronta,
  output logic                         nota_aceita,
  output logic [$clog2(NUM_VOZES)-1:0] nota_voz,
  input  logic                         solta_valida,
  input  logic [$clog2(NUM_VOZES)-1:0] solta_voz,
  output logic [NUM_VOZES-1:0]         prox,
  output logic [NUM_VOZES-1:0]         ativo,
  output logic [NUM_VOZES-1:0]         ocupado
);
  localparam int VW = $clog2(NUM_VOZES);
  localparam int FW = $clog2(SAMPLE_SIZE);

  typedef enum logic [1:0] {LIVRE, INICIO, TOCANDO, LIBERANDO} estado_t;

  logic [NUM_VOZES-1:0]   livre;
  logic                   tem_livre;
  logic [VW-1:0]          alvo_livre;
  logic [VW-1:0]          alvo;
  logic                   aceita;
  logic [LARGURA_DIV-1:0] nd_in;
  logic                   nota_aceita_reg;
  logic [VW-1:0]          nota_voz_reg;

  // Divisors below 2 would leave no room for the INICIO cycle, so clamp them.
  assign nd_in = (nota_div < LARGURA_DIV'(2)) ? LARGURA_DIV'(2) : nota_div;

  // Lowest-index free voice.
  always_comb begin
    tem_livre  = 1'b0;
    alvo_livre = '0;
    for (int i = NUM_VOZES - 1; i >= 0; i--) begin
      if (livre[i]) begin
        tem_livre  = 1'b1;
        alvo_livre = VW'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [NUM_VOZES-1:0] liberando;
  logic                 tem_lib;
  logic [VW-1:0]        alvo_lib;
  logic [VW-1:0]        ptr_reg;

  // Lowest-index releasing voice: the cheapest one to steal.
  always_comb begin
    tem_lib  = 1'b0;
    alvo_lib = '0;
    for (int i = NUM_VOZES - 1; i >= 0; i--) begin
      if (liberando[i]) begin
        tem_lib  = 1'b1;
        alvo_lib = VW'(i);
      end
    end
  end

  assign nota_pronta = 1'b1;
  assign alvo = tem_livre ? alvo_livre : (tem_lib ? alvo_lib : ptr_reg);

  // Round-robin steal pointer, advanced only when it actually picks the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (aceita && !tem_livre && !tem_lib) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end
`else
  assign nota_pronta = tem_livre;
  assign alvo        = alvo_livre;
`endif

  assign aceita = nota_valida && nota_pronta;

  // Acceptance handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nota_aceita_reg <= 1'b0;
      nota_voz_reg    <= '0;
    end else begin
      nota_aceita_reg <= aceita;
      if (aceita) nota_voz_reg <= alvo;
    end
  end

  assign nota_aceita = nota_aceita_reg;
  assign nota_voz    = nota_voz_reg;

  genvar gi;
  for (gi = 0; gi < NUM_VOZES; gi++) begin : g_voz
    estado_t                est_reg, est_next;
    logic [LARGURA_DIV-1:0] cont_reg, cont_next;
    logic [LARGURA_DIV-1:0] nd_reg, nd_next;
    logic [FW-1:0]          fase_reg, fase_next;
    logic                   prox_reg, prox_next;
    logic                   ativo_reg, ativo_next;
    logic                   pega, solta, passo;

    assign pega  = aceita && (alvo == VW'(gi));
    assign solta = solta_valida && (solta_voz == VW'(gi));
    assign passo = (cont_reg == '0);

    // Voice state machine; prox/ativo are computed one cycle ahead and registered.
    always_comb begin
      est_next   = est_reg;
      cont_next  = cont_reg;
      nd_next    = nd_reg;
      fase_next  = fase_reg;
      prox_next  = 1'b0;
      ativo_next = 1'b0;
      if (pega) begin
        // A new note always wins over a same-cycle note-off.
        est_next  = INICIO;
        nd_next   = nd_in;
        cont_next = nd_in - 1'b1;
        fase_next = '0;
        prox_next = 1'b1;
      end else begin
        case (est_reg)
          INICIO: begin
            cont_next = cont_reg - 1'b1;
            if (solta) begin
              est_next = LIVRE;
            end else begin
              est_next   = TOCANDO;
              ativo_next = 1'b1;
            end
          end
          TOCANDO, LIBERANDO: begin
            if (est_reg == TOCANDO && solta && fase_reg == '0) begin
              // Already sitting on sample[0]: stop right away.
              est_next = LIVRE;
            end else begin
              if (est_reg == TOCANDO && solta) est_next = LIBERANDO;
              ativo_next = 1'b1;
              if (passo) begin
                prox_next = 1'b1;
                cont_next = nd_reg - 1'b1;
                fase_next = fase_reg + 1'b1;
                // The wrapping strobe still goes out gated, landing on sample[0].
                if (est_next == LIBERANDO && fase_reg == FW'(SAMPLE_SIZE - 1)) est_next = LIVRE;
              end else begin
                cont_next = cont_reg - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Voice state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        est_reg   <= LIVRE;
        cont_reg  <= '0;
        nd_reg    <= '0;
        fase_reg  <= '0;
        prox_reg  <= 1'b0;
        ativo_reg <= 1'b0;
      end else begin
        est_reg   <= est_next;
        cont_reg  <= cont_next;
        nd_reg    <= nd_next;
        fase_reg  <= fase_next;
        prox_reg  <= prox_next;
        ativo_reg <= ativo_next;
      end
    end

    assign livre[gi]   = (est_reg == LIVRE);
    assign ocupado[gi] = (est_reg != LIVRE);
    assign prox[gi]    = prox_reg;
    assign ativo[gi]   = ativo_reg;
`ifdef VOICE_STEAL_EN
    assign liberando[gi] = (est_reg == LIBERANDO);
`endif
  end

endmodule

// File: tb/tb_escalonador_vozes.sv
// Testbench for escalonador_vozes: directed scenarios plus random traffic,
// checked against a timestamp-based model of each voice.
module tb_escalonador_vozes;
  localparam int NV = 4;
  localparam int LD = 16;
  localparam int SS = 8;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          nota_valida = 1'b0;
  logic [LD-1:0] nota_div = '0;
  logic          nota_pronta;
  logic          nota_aceita;
  logic [VW-1:0] nota_voz;
  logic          solta_valida = 1'b0;
  logic [VW-1:0] solta_voz = '0;
  logic [NV-1:0] prox, ativo, ocupado;

  int checks = 0;
  int errors = 0;

  escalonador_vozes #(.NUM_VOZES(NV), .LARGURA_DIV(LD), .SAMPLE_SIZE(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .nota_valida(nota_valida), .nota_div(nota_div), .nota_pronta(nota_pronta),
    .nota_aceita(nota_aceita), .nota_voz(nota_voz),
    .solta_valida(solta_valida), .solta_voz(solta_voz),
    .prox(prox), .ativo(ativo), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Model: per voice, status (0 free, 1 playing, 2 releasing), the cycle of its
  // INICIO strobe and its divisor. Strobes and phase follow from elapsed time.
  int st[NV];
  int t0[NV];
  int nd[NV];
  int cyc;
  int ptr;
  logic [NV-1:0] e_prox, e_ativo, e_ocup;
  logic          e_pronta, e_aceita;
  logic [VW-1:0] e_voz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      st[v] = 0; t0[v] = 0; nd[v] = 2;
    end
    cyc = 0; ptr = 0;
    e_prox = '0; e_ativo = '0; e_ocup = '0;
    e_pronta = 1'b1; e_aceita = 1'b0; e_voz = '0;
  endtask

  // Predict outputs after the coming edge from the inputs currently driven.
  task automatic model_step();
    int k, tgt, fase_pre, s;
    int nst[NV];
    bit ini, stb, off, any_free, acc;
    k = cyc + 1;
    any_free = 0;
    tgt = -1;
    for (int v = 0; v < NV; v++) if (st[v] == 0) any_free = 1;
    for (int v = 0; v < NV; v++) begin
      nst[v] = st[v];
      e_prox[v] = 1'b0;
      e_ativo[v] = 1'b0;
      off = solta_valida && (int'(solta_voz) == v);
      if (st[v] != 0) begin
        ini = (cyc == t0[v]);
        stb = ((k - t0[v]) % nd[v]) == 0;
        s = (k - t0[v]) / nd[v];
        fase_pre = ((cyc - t0[v]) / nd[v]) % SS;
        if (ini) begin
          if (off) nst[v] = 0;
          else begin nst[v] = 1; e_ativo[v] = 1'b1; end
        end else if (st[v] == 1 && off && fase_pre == 0) begin
          nst[v] = 0;
        end else begin
          if (st[v] == 1 && off) nst[v] = 2;
          e_prox[v] = stb;
          e_ativo[v] = 1'b1;
          if (nst[v] == 2 && stb && (s % SS) == 0) nst[v] = 0;
        end
      end
    end
`ifdef VOICE_STEAL_EN
    acc = nota_valida;
`else
    acc = nota_valida && any_free;
`endif
    if (acc) begin
      for (int v = NV - 1; v >= 0; v--) if (st[v] == 0) tgt = v;
`ifdef VOICE_STEAL_EN
      if (tgt < 0) for (int v = NV - 1; v >= 0; v--) if (st[v] == 2) tgt = v;
      if (tgt < 0) begin tgt = ptr; ptr = (ptr + 1) % NV; end
`endif
      nst[tgt] = 1;
      t0[tgt] = k;
      nd[tgt] = (nota_div < 2) ? 2 : int'(nota_div);
      e_prox[tgt] = 1'b1;
      e_ativo[tgt] = 1'b0;
      e_voz = VW'(tgt);
    end
    e_aceita = acc;
    any_free = 0;
    for (int v = 0; v < NV; v++) begin
      st[v] = nst[v];
      e_ocup[v] = (nst[v] != 0);
      if (nst[v] == 0) any_free = 1;
    end
`ifdef VOICE_STEAL_EN
    e_pronta = 1'b1;
`else
    e_pronta = any_free;
`endif
    cyc = k;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("prox", prox, e_prox);
    check("ativo", ativo, e_ativo);
    check("ocupado", ocupado, e_ocup);
    check("nota_pronta", nota_pronta, e_pronta);
    check("nota_aceita", nota_aceita, e_aceita);
    check("nota_voz", nota_voz, e_voz);
    if (e_aceita) $display("note accepted: voz=%0d nd=%0d t=%0t", e_voz, nd[e_voz], $time);
  endtask

  task automatic idle(input int n);
    nota_valida = 1'b0;
    solta_valida = 1'b0;
    repeat (n) tick();
  endtask

  task automatic note_on(input int div);
    nota_valida = 1'b1;
    nota_div = LD'(div);
    tick();
    nota_valida = 1'b0;
  endtask

  task automatic note_off(input int v);
    solta_valida = 1'b1;
    solta_voz = VW'(v);
    tick();
    solta_valida = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_prox", prox, 0);
    check("rst_ativo", ativo, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_aceita", nota_aceita, 0);
    check("rst_voz", nota_voz, 0);
    nota_valida = 1'b0;
    solta_valida = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
    check("rst_pronta", nota_pronta, 1);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_prox", prox, 0);
    check("init_ocupado", ocupado, 0);
    check("init_aceita", nota_aceita, 0);
    #2;
    rst_n = 1'b1;
    check("init_pronta", nota_pronta, 1);

    // Single note, divisor 5, released after three steps.
    note_on(5);
    check("single_voz", nota_voz, 0);
    check("single_inicio_prox", prox[0], 1);
    check("single_inicio_ativo", ativo[0], 0);
    idle(5);
    check("single_step1_prox", prox[0], 1);
    check("single_step1_ativo", ativo[0], 1);
    idle(10);
    note_off(0);
    idle(24);
    check("release_last_prox", prox[0], 1);
    check("release_last_ativo", ativo[0], 1);
    check("release_free", ocupado[0], 0);
    idle(1);
    check("release_gate_off", ativo[0], 0);

    // Note-off while still on phase 0 stops on the next cycle.
    note_on(4);
    idle(1);
    note_off(0);
    check("off_fase0_free", ocupado[0], 0);
    check("off_fase0_ativo", ativo[0], 0);

    // Divisors 0 and 1 behave as 2.
    for (int d = 0; d < 2; d++) begin
      note_on(d);
      idle(2);
      check("mindiv_step1", prox[0], 1);
      idle(1);
      check("mindiv_gap", prox[0], 0);
      idle(1);
      check("mindiv_step2", prox[0], 1);
      note_off(0);
      idle(20);
      check("mindiv_free", ocupado, 0);
    end

    // Fill every voice, then a fifth request waits for a release.
    for (int i = 0; i < NV; i++) begin
      nota_valida = 1'b1;
      nota_div = LD'(3 + i);
      tick();
      check("fill_voz", nota_voz, i);
    end
    check("fill_pronta", nota_pronta, 0);
    nota_div = LD'(6);
    repeat (3) tick();
    solta_valida = 1'b1;
    solta_voz = '0;
    tick();
    solta_valida = 1'b0;
    n = 0;
    while (nota_aceita !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    nota_valida = 1'b0;
    check("fill5_wait", n < 200, 1);
    check("fill5_voz", nota_voz, 0);
    idle(7);

    // Reset with notes sounding.
    do_reset();
    idle(3);

    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      nota_valida = ($urandom % 4) == 0;
      nota_div = LD'($urandom_range(0, 6));
      solta_valida = ($urandom % 5) == 0;
      solta_voz = VW'($urandom_range(0, NV - 1));
      tick();
    end
    idle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
